// File: rtl/interlaken_encode_67b_if.sv
// interlaken_encode_67b_if: bus bundle for the multi-lane 64B/67B transmit encoder.
// Ports (all carried in the bundle, clock/reset stay outside):
//   PASSTHROUGH, TX_VALID_IN, DATA_IN[64*LANES], HEADER_IN[2*LANES] : framing layer -> encoder
//   TX_READY_OUT                                                    : encoder -> framing layer
//   TX_VALID_OUT, DATA_OUT[67*LANES], HDR_ERR[LANES]                : encoder -> gearbox
//   TX_READY_IN                                                     : gearbox -> encoder
// master = the side driving words in and accepting words out; slave = the encoder.
interface interlaken_encode_67b_if #(
    parameter int LANES = 4
);
    logic                PASSTHROUGH;
    logic                TX_VALID_IN;
    logic                TX_READY_OUT;
    logic [64*LANES-1:0] DATA_IN;
    logic [2*LANES-1:0]  HEADER_IN;
    logic                TX_VALID_OUT;
    logic                TX_READY_IN;
    logic [67*LANES-1:0] DATA_OUT;
    logic [LANES-1:0]    HDR_ERR;

    modport master (
        output PASSTHROUGH, TX_VALID_IN, DATA_IN, HEADER_IN, TX_READY_IN,
        input  TX_READY_OUT, TX_VALID_OUT, DATA_OUT, HDR_ERR
    );

    modport slave (
        input  PASSTHROUGH, TX_VALID_IN, DATA_IN, HEADER_IN, TX_READY_IN,
        output TX_READY_OUT, TX_VALID_OUT, DATA_OUT, HDR_ERR
    );
endinterface

// File: rtl/interlaken_encode_67b.sv
// interlaken_encode_67b: LANES-wide Interlaken 64B/67B transmit encoder, 2-stage valid/ready pipeline.
// Ports:
//   USER_CLK      : clock, rising edge
//   SYSTEM_RESET  : asynchronous active-high reset
//   bus (slave)   : PASSTHROUGH/TX_VALID_IN/TX_READY_OUT/DATA_IN/HEADER_IN in,
//                   TX_VALID_OUT/TX_READY_IN/DATA_OUT/HDR_ERR out
// Lane l output: [67l+66] inversion bit, [67l+65:67l+64] header, [67l+63:67l] payload.
// Optional macro ENC67_HDR_CHECK_EN builds the sticky per-lane illegal-header flags;
// without it HDR_ERR is tied low.
module interlaken_encode_67b #(
    parameter int LANES      = 4,
    parameter int DISP_WIDTH = 10
) (
    input logic USER_CLK,
    input logic SYSTEM_RESET,
    interlaken_encode_67b_if.slave bus
);
    logic                             en;
    logic                             load;
    logic                             s1_valid_q, s1_valid_d;
    logic                             s1_pt_q, s1_pt_d;
    logic [64*LANES-1:0]              s1_data_q, s1_data_d;
    logic [2*LANES-1:0]               s1_hdr_q, s1_hdr_d;
    logic [LANES-1:0][7:0]            s1_w_q, s1_w_d, w_in;
    logic                             valid_out_q, valid_out_d;
    logic [LANES-1:0][66:0]           data_out_q, data_out_d, lane_out;
    logic [LANES-1:0][DISP_WIDTH-1:0] rd_q, rd_d, rd_next;

    assign en               = ~valid_out_q | bus.TX_READY_IN;
    assign load             = en & s1_valid_q;
    assign bus.TX_READY_OUT = en;
    assign bus.TX_VALID_OUT = valid_out_q;
    assign bus.DATA_OUT     = data_out_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [63:0] d;
        logic [1:0]  h;
        logic [7:0]  w;
        logic [7:0]  delta;
        logic        inv;
        // Weight of the raw 66 bits: ones minus zeros, always even.
        assign w_in[l] = 8'(2 * $countones({bus.HEADER_IN[2*l +: 2], bus.DATA_IN[64*l +: 64]}) - 66);
        assign d       = s1_data_q[64*l +: 64];
        assign h       = s1_hdr_q[2*l +: 2];
        assign w       = s1_w_q[l];
        // Invert when the word would push rd further from zero; a balanced word never inverts.
        assign inv         = ~s1_pt_q & (rd_q[l][DISP_WIDTH-1] ? w[7] : (~w[7] & |w));
        assign lane_out[l] = {inv, h, inv ? ~d : d};
        // Disparity of the full 67-bit word, inversion bit included.
        assign delta      = 8'(2 * $countones(lane_out[l]) - 67);
        assign rd_next[l] = s1_pt_q ? '0 : rd_q[l] + {{(DISP_WIDTH-8){delta[7]}}, delta};
    end

    always_comb begin
        s1_valid_d  = en ? bus.TX_VALID_IN : s1_valid_q;
        s1_pt_d     = en ? bus.PASSTHROUGH : s1_pt_q;
        s1_data_d   = en ? bus.DATA_IN : s1_data_q;
        s1_hdr_d    = en ? bus.HEADER_IN : s1_hdr_q;
        s1_w_d      = en ? w_in : s1_w_q;
        valid_out_d = en ? s1_valid_q : valid_out_q;
        data_out_d  = load ? lane_out : data_out_q;
        rd_d        = load ? rd_next : rd_q;
    end

    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            s1_valid_q  <= 1'b0;
            s1_pt_q     <= 1'b0;
            s1_data_q   <= '0;
            s1_hdr_q    <= '0;
            s1_w_q      <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            rd_q        <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_pt_q     <= s1_pt_d;
            s1_data_q   <= s1_data_d;
            s1_hdr_q    <= s1_hdr_d;
            s1_w_q      <= s1_w_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            rd_q        <= rd_d;
        end
    end

`ifdef ENC67_HDR_CHECK_EN
    logic [LANES-1:0] hdr_err_q, hdr_err_d, hdr_bad;

    for (genvar l = 0; l < LANES; l++) begin : g_hdr
        // 00 and 11 are not legal Interlaken framing headers.
        assign hdr_bad[l] = s1_hdr_q[2*l+1] ~^ s1_hdr_q[2*l];
    end

    always_comb begin
        hdr_err_d = hdr_err_q | (load ? hdr_bad : '0);
    end

    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) hdr_err_q <= '0;
        else hdr_err_q <= hdr_err_d;
    end

    assign bus.HDR_ERR = hdr_err_q;
`else
    assign bus.HDR_ERR = '0;
`endif
endmodule
